multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencer for the RV32I core. It steps one instruction at a time through FETCH, DECODE, EXEC, MEM and WB, and drives the datapath enables and selects: PC, IR, register file, ALU, immediate format and writeback mux. It owns the single shared instruction/data memory port through a req/ready handshake. It replaces the per-opcode combinational selection in the single-cycle datapath with registered, state-driven control.

## Interface
- `MEM_TIMEOUT`, default 255: cycles to wait for `mem_ready` before trapping. Range 1..255; 0 disables the timeout.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `Instr`  in  32  IR contents, valid from DECODE onward
- `br_taken`  in  1  branch condition from the datapath comparator, valid in EXEC
- `mem_ready`  in  1  memory accepted/completed the current `mem_req`
- `mem_req`  out  1  memory request
- `mem_we`  out  1  request is a store
- `mem_isel`  out  1  1 = address from PC (fetch), 0 = address from ALU result
- `pc_we`  out  1  PC write enable
- `pc_sel`  out  1  0 = PC+4, 1 = ALU/branch target
- `ir_we`  out  1  IR and old-PC latch enable
- `reg_we`  out  1  register file write enable
- `alu_src_b`  out  1  0 = rs2, 1 = immediate
- `alu_op`  out  2  0 = ADD, 1 = SUB, 2 = use funct3/funct7
- `imm_sel`  out  3  0 = I, 1 = S, 2 = B, 3 = J, 4 = U
- `wb_sel`  out  2  0 = ALU, 1 = MEM, 2 = PC+4
- `trap`  out  1  illegal opcode or memory timeout; sticky
- `cycle_cnt`, `instret_cnt`  out  32 each  performance counters (see Configuration)

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. The state register is the only source of sequencing.
- Outputs are Moore, decoded from the state and `Instr[6:0]`. Every output not named for a state is 0 in that state.
- **FETCH**
  - Drives `mem_req=1`, `mem_isel=1`.
  - When `mem_ready`=1: pulses `ir_we`, `pc_we` with `pc_sel=0`, then moves to DECODE.
- **DECODE**
  - Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL, 0110111 LUI.
  - Any other opcode goes to TRAP. Legal opcodes go to EXEC.
- **EXEC**
  - R: `alu_op=2`, `alu_src_b=0`; next WB.
  - I-ALU: `alu_op=2`, `alu_src_b=1`, `imm_sel=0`; next WB.
  - Load/store: `alu_op=0`, `alu_src_b=1`, `imm_sel` 0 for load, 1 for store; next MEM.
  - Branch: `alu_op=1`, `imm_sel=2`. `pc_we=br_taken`, `pc_sel=1`. Next FETCH.
  - JAL: `imm_sel=3`, `pc_we=1`, `pc_sel=1`, `reg_we=1`, `wb_sel=2`. Next FETCH.
  - LUI: `imm_sel=4`, `alu_src_b=1`, `alu_op=0`; next WB. The datapath forces operand A to 0 for opcode 0110111.
- **MEM**
  - Drives `mem_req=1`, `mem_isel=0`, `mem_we` = store.
  - On `mem_ready`: store goes to FETCH, load goes to WB.
- **WB**: `reg_we=1`, `wb_sel` = 1 for load, else 0. Next FETCH.
- **TRAP**: `trap=1`, all other outputs 0. Exits only on reset.
- **Memory timeout**
  - An 8-bit wait counter clears on entry to FETCH or MEM and increments each cycle `mem_req`=1 and `mem_ready`=0.
  - When the counter reaches `MEM_TIMEOUT` (nonzero), the next state is TRAP.
- **Handshake rules**
  - `mem_req`, `mem_we` and `mem_isel` stay stable until `mem_ready` is sampled high.
  - `mem_ready` while `mem_req`=0 is ignored.
  - `mem_ready` high in the same cycle `mem_req` rises completes the transfer in that cycle.

## Timing
- Reset, asynchronous: state = FETCH, wait counter = 0, counters = 0, `trap` = 0.
- Out of reset, FETCH drives `mem_req`=1 in the first cycle.
- Minimum latency with zero-wait memory, FETCH entry to next FETCH entry:
  - branch / JAL: 3 cycles
  - R / I-ALU / LUI / store: 4 cycles
  - load: 5 cycles
- Each wait cycle of `mem_ready` adds exactly one cycle.
- Reset asserted mid-instruction: all outputs drop to reset values immediately, with no partial writes after reset assertion.

## Configuration
- Macro `MCTRL_PERF_CNT_EN`.
- **Defined**
  - `cycle_cnt` increments every cycle outside TRAP.
  - `instret_cnt` increments on every transition into FETCH from EXEC, MEM or WB.
  - Both wrap modulo 2^32.
- **Undefined**: both outputs are tied to 0 and no counter flops are built.

## Structure
- Package `rv32i_ctrl_pkg` holds:
  - opcode constants
  - the state enum
  - `imm_sel`, `wb_sel` and `alu_op` encodings (shared with the immediate generator and writeback mux)
- Sub-module `mcyc_decode`: combinational `Instr[6:0]` → instruction-class one-hot plus `legal` flag. It is instantiated once and used by both the next-state and output logic.

## Test plan
- ADD x3,x1,x2 (0x002081B3), `mem_ready` tied 1 → states F,D,E,W; `reg_we`=1 for one cycle with `wb_sel`=0; `instret_cnt`=1 after 4 cycles.
- LW (0x0000A183), `mem_ready` low for 3 cycles in MEM → total 8 cycles; `mem_req`/`mem_we`=1/0 stable throughout the wait; WB with `wb_sel`=1.
- BEQ (0x00208463) with `br_taken`=0 then 1 → `pc_we`=0 vs 1 in EXEC, `imm_sel`=2; no `reg_we` either time.
- Opcode 0x7F → TRAP after DECODE; `trap`=1, `mem_req`=0 for 20 further cycles, `cycle_cnt` frozen.
- `MEM_TIMEOUT`=4, `mem_ready` held 0 in FETCH → TRAP on the 5th cycle; with `MEM_TIMEOUT`=0 → no trap after 1000 cycles.
- `rst_n` pulsed low during MEM of a store → `mem_req`, `mem_we` and counters are 0 within the reset cycle; FETCH resumes after release.

Source files
------------

// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes, sequencer
// states, and the select encodings seen by the immediate generator and writeback mux.
package rv32i_ctrl_pkg;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam int unsigned WAIT_CNT_W = 8;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_J = 3'd3,
      IMM_U = 3'd4
   } imm_sel_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_e;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'd0,
      ALU_SUB   = 2'd1,
      ALU_FUNCT = 2'd2
   } alu_op_e;

   // At most one bit set; all clear means the opcode is not supported.
   typedef struct packed {
      logic r;
      logic i_alu;
      logic load;
      logic store;
      logic branch;
      logic jal;
      logic lui;
   } instr_class_t;

endpackage

// File: rtl/mcyc_decode.sv
// Opcode classifier: Instr[6:0] to a one-hot instruction class plus a legal flag.
module mcyc_decode
   import rv32i_ctrl_pkg::*;
(
   input  logic [6:0]   opcode,
   output instr_class_t cls,
   output logic         legal
);

   always_comb begin
      cls = '0;
      case (opcode)
         OPC_R:      cls.r      = 1'b1;
         OPC_I_ALU:  cls.i_alu  = 1'b1;
         OPC_LOAD:   cls.load   = 1'b1;
         OPC_STORE:  cls.store  = 1'b1;
         OPC_BRANCH: cls.branch = 1'b1;
         OPC_JAL:    cls.jal    = 1'b1;
         OPC_LUI:    cls.lui    = 1'b1;
         default:    cls        = '0;
      endcase
      legal = |cls;
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP) with memory timeout.
// Performance counters are built only when MCTRL_PERF_CNT_EN is defined.
module multicycle_ctrl
   import rv32i_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] Instr,
   input  logic        br_taken,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_isel,
   output logic        pc_we,
   output logic        pc_sel,
   output logic        ir_we,
   output logic        reg_we,
   output logic        alu_src_b,
   output logic [1:0]  alu_op,
   output logic [2:0]  imm_sel,
   output logic [1:0]  wb_sel,
   output logic        trap,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instret_cnt
);

   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(MEM_TIMEOUT);
   localparam bit                    TIMEOUT_EN  = (MEM_TIMEOUT != 0);

   state_e                  state;
   state_e                  state_nxt;
   logic [WAIT_CNT_W-1:0]   wait_cnt;
   instr_class_t            cls;
   logic                    legal;
   logic                    wait_cyc;
   logic                    timeout;
   logic                    instr_hi_unused;

   assign instr_hi_unused = ^Instr[31:7];

   mcyc_decode u_decode (
      .opcode (Instr[6:0]),
      .cls    (cls),
      .legal  (legal)
   );

   assign wait_cyc = mem_req && !mem_ready;
   // Fires on the wait cycle that brings the count up to the limit.
   assign timeout  = TIMEOUT_EN && wait_cyc && ((wait_cnt + 8'd1) == TIMEOUT_VAL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_FETCH: begin
            if (mem_ready) begin
               state_nxt = ST_DECODE;
            end else if (timeout) begin
               state_nxt = ST_TRAP;
            end
         end
         ST_DECODE: state_nxt = legal ? ST_EXEC : ST_TRAP;
         ST_EXEC: begin
            if (cls.r || cls.i_alu || cls.lui) begin
               state_nxt = ST_WB;
            end else if (cls.load || cls.store) begin
               state_nxt = ST_MEM;
            end else if (cls.branch || cls.jal) begin
               state_nxt = ST_FETCH;
            end else begin
               state_nxt = ST_TRAP;
            end
         end
         ST_MEM: begin
            if (mem_ready) begin
               state_nxt = cls.store ? ST_FETCH : ST_WB;
            end else if (timeout) begin
               state_nxt = ST_TRAP;
            end
         end
         ST_WB:   state_nxt = ST_FETCH;
         ST_TRAP: state_nxt = ST_TRAP;
         default: state_nxt = ST_TRAP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if ((state_nxt != state) &&
                   ((state_nxt == ST_FETCH) || (state_nxt == ST_MEM))) begin
         wait_cnt <= '0;
      end else if (wait_cyc) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   // Outputs are held at zero while rst_n is low so nothing is written mid-reset.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_isel  = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 1'b0;
      ir_we     = 1'b0;
      reg_we    = 1'b0;
      alu_src_b = 1'b0;
      alu_op    = ALU_ADD;
      imm_sel   = IMM_I;
      wb_sel    = WB_ALU;
      trap      = 1'b0;
      if (rst_n) begin
         case (state)
            ST_FETCH: begin
               mem_req  = 1'b1;
               mem_isel = 1'b1;
               ir_we    = mem_ready;
               pc_we    = mem_ready;
            end
            ST_EXEC: begin
               if (cls.r) begin
                  alu_op = ALU_FUNCT;
               end
               if (cls.i_alu) begin
                  alu_op    = ALU_FUNCT;
                  alu_src_b = 1'b1;
                  imm_sel   = IMM_I;
               end
               if (cls.load || cls.store) begin
                  alu_op    = ALU_ADD;
                  alu_src_b = 1'b1;
                  imm_sel   = cls.store ? IMM_S : IMM_I;
               end
               if (cls.branch) begin
                  alu_op  = ALU_SUB;
                  imm_sel = IMM_B;
                  pc_we   = br_taken;
                  pc_sel  = 1'b1;
               end
               if (cls.jal) begin
                  imm_sel = IMM_J;
                  pc_we   = 1'b1;
                  pc_sel  = 1'b1;
                  reg_we  = 1'b1;
                  wb_sel  = WB_PC4;
               end
               if (cls.lui) begin
                  imm_sel   = IMM_U;
                  alu_src_b = 1'b1;
                  alu_op    = ALU_ADD;
               end
            end
            ST_MEM: begin
               mem_req = 1'b1;
               mem_we  = cls.store;
            end
            ST_WB: begin
               reg_we = 1'b1;
               wb_sel = cls.load ? WB_MEM : WB_ALU;
            end
            ST_TRAP: trap = 1'b1;
            default: ;
         endcase
      end
   end

`ifdef MCTRL_PERF_CNT_EN
   logic [31:0] cycle_q;
   logic [31:0] instret_q;
   logic        retire;

   assign retire = (state_nxt == ST_FETCH) &&
                   ((state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         if (state != ST_TRAP) begin
            cycle_q <= cycle_q + 32'd1;
         end
         if (retire) begin
            instret_q <= instret_q + 32'd1;
         end
      end
   end

   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed table, random instruction
// stream against a phase-level reference model, and timeout/reset corner cases.
module tb_multicycle_ctrl;

   typedef enum int {P_F, P_D, P_E, P_M, P_W, P_T} phase_t;
   typedef enum int {C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_LUI, C_BAD} cls_t;

   typedef struct {
      logic [31:0] ins;
      logic        br;
      int          regw;
      int          pcw;
      int          wb;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main DUT (default timeout)
   logic        rst_n, br_taken, mem_ready;
   logic [31:0] Instr;
   logic        mem_req, mem_we, mem_isel, pc_we, pc_sel, ir_we, reg_we, alu_src_b, trap;
   logic [1:0]  alu_op, wb_sel;
   logic [2:0]  imm_sel;
   logic [31:0] cycle_cnt, instret_cnt;
   logic [15:0] act;

   assign act = {mem_req, mem_we, mem_isel, pc_we, pc_sel, ir_we, reg_we, alu_src_b,
                 alu_op, imm_sel, wb_sel, trap};

   multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .Instr(Instr), .br_taken(br_taken), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_isel(mem_isel), .pc_we(pc_we), .pc_sel(pc_sel),
      .ir_we(ir_we), .reg_we(reg_we), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .imm_sel(imm_sel), .wb_sel(wb_sel), .trap(trap),
      .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   // timeout instances share one set of inputs
   logic        rst2, br2, rdy2;
   logic [31:0] instr2;
   logic        a_req, a_we, a_isel, a_pcwe, a_pcsel, a_irwe, a_regwe, a_asrc, a_trap;
   logic [1:0]  a_aop, a_wb;
   logic [2:0]  a_imm;
   logic [31:0] a_cyc, a_ret;
   logic        b_req, b_we, b_isel, b_pcwe, b_pcsel, b_irwe, b_regwe, b_asrc, b_trap;
   logic [1:0]  b_aop, b_wb;
   logic [2:0]  b_imm;
   logic [31:0] b_cyc, b_ret;

   multicycle_ctrl #(.MEM_TIMEOUT(4)) dut_t4 (
      .clk(clk), .rst_n(rst2), .Instr(instr2), .br_taken(br2), .mem_ready(rdy2),
      .mem_req(a_req), .mem_we(a_we), .mem_isel(a_isel), .pc_we(a_pcwe), .pc_sel(a_pcsel),
      .ir_we(a_irwe), .reg_we(a_regwe), .alu_src_b(a_asrc), .alu_op(a_aop),
      .imm_sel(a_imm), .wb_sel(a_wb), .trap(a_trap), .cycle_cnt(a_cyc), .instret_cnt(a_ret)
   );

   multicycle_ctrl #(.MEM_TIMEOUT(0)) dut_t0 (
      .clk(clk), .rst_n(rst2), .Instr(instr2), .br_taken(br2), .mem_ready(rdy2),
      .mem_req(b_req), .mem_we(b_we), .mem_isel(b_isel), .pc_we(b_pcwe), .pc_sel(b_pcsel),
      .ir_we(b_irwe), .reg_we(b_regwe), .alu_src_b(b_asrc), .alu_op(b_aop),
      .imm_sel(b_imm), .wb_sel(b_wb), .trap(b_trap), .cycle_cnt(b_cyc), .instret_cnt(b_ret)
   );

   int n_err = 0;
   int n_chk = 0;
   int m_cycles = 0;
   int m_instret = 0;
   int n_regwe, n_pcwe, last_wb;

   function automatic logic [31:0] exp_cnt(input int v);
`ifdef MCTRL_PERF_CNT_EN
      return 32'(v);
`else
      return (v < 0) ? 32'd1 : 32'd0;
`endif
   endfunction

   function automatic cls_t classify(input logic [31:0] ins);
      case (ins[6:0])
         7'b0110011: return C_R;
         7'b0010011: return C_I;
         7'b0000011: return C_LD;
         7'b0100011: return C_ST;
         7'b1100011: return C_BR;
         7'b1101111: return C_JAL;
         7'b0110111: return C_LUI;
         default:    return C_BAD;
      endcase
   endfunction

   // Expected control word for one cycle of a phase, straight from the control table.
   function automatic logic [15:0] exp_out(input phase_t p, input cls_t c,
                                           input logic rdy, input logic br);
      logic       mreq = 1'b0, mwe = 1'b0, misel = 1'b0, pcwe = 1'b0, pcsel = 1'b0;
      logic       irwe = 1'b0, regwe = 1'b0, asrc = 1'b0, trp = 1'b0;
      logic [1:0] aop = 2'd0, wb = 2'd0;
      logic [2:0] imm = 3'd0;
      case (p)
         P_F: begin mreq = 1'b1; misel = 1'b1; irwe = rdy; pcwe = rdy; end
         P_E: begin
            case (c)
               C_R:   aop = 2'd2;
               C_I:   begin aop = 2'd2; asrc = 1'b1; end
               C_LD:  asrc = 1'b1;
               C_ST:  begin asrc = 1'b1; imm = 3'd1; end
               C_BR:  begin aop = 2'd1; imm = 3'd2; pcwe = br; pcsel = 1'b1; end
               C_JAL: begin imm = 3'd3; pcwe = 1'b1; pcsel = 1'b1; regwe = 1'b1; wb = 2'd2; end
               C_LUI: begin imm = 3'd4; asrc = 1'b1; end
               default: ;
            endcase
         end
         P_M: begin mreq = 1'b1; mwe = (c == C_ST); end
         P_W: begin regwe = 1'b1; wb = (c == C_LD) ? 2'd1 : 2'd0; end
         P_T: trp = 1'b1;
         default: ;
      endcase
      return {mreq, mwe, misel, pcwe, pcsel, irwe, regwe, asrc, aop, imm, wb, trp};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h", nm, got, exp);
      end
   endtask

   task automatic step(input phase_t p, input cls_t c, input logic [31:0] ins,
                       input logic rdy, input logic br, input string tag);
      Instr = ins; mem_ready = rdy; br_taken = br;
      @(negedge clk);
      chk($sformatf("%s/%s ctl", tag, p.name()), 32'(act), 32'(exp_out(p, c, rdy, br)));
      if (reg_we) begin n_regwe++; last_wb = int'(wb_sel); end
      if (pc_we) n_pcwe++;
      @(posedge clk); #1;
      if (p != P_T) m_cycles++;
   endtask

   task automatic run_instr(input logic [31:0] ins, input logic br, input int fw, input int mw,
                            input string tag);
      cls_t c;
      c = classify(ins);
      for (int k = 0; k <= fw; k++) step(P_F, c, $urandom, k == fw, 1'($urandom), tag);
      step(P_D, c, ins, 1'($urandom), br, tag);
      if (c == C_BAD) return;
      step(P_E, c, ins, 1'($urandom), br, tag);
      if (c == C_LD || c == C_ST)
         for (int k = 0; k <= mw; k++) step(P_M, c, ins, k == mw, br, tag);
      if (c == C_R || c == C_I || c == C_LUI || c == C_LD)
         step(P_W, c, ins, 1'($urandom), br, tag);
      m_instret++;
      chk({tag, " cycle_cnt"}, cycle_cnt, exp_cnt(m_cycles));
      chk({tag, " instret_cnt"}, instret_cnt, exp_cnt(m_instret));
   endtask

   task automatic do_reset();
      rst_n = 1'b0; mem_ready = 1'b0; Instr = '0; br_taken = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_cycles = 0; m_instret = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      n_err++;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [8];
      logic [6:0]  opc_tbl [7];
      logic [31:0] r, ins;
      logic [31:0] cyc_frozen;

      tbl[0] = '{32'h002081B3, 1'b0, 1, 1, 0};  // ADD
      tbl[1] = '{32'h00108093, 1'b0, 1, 1, 0};  // ADDI
      tbl[2] = '{32'h0000A183, 1'b0, 1, 1, 1};  // LW
      tbl[3] = '{32'h0020A023, 1'b0, 0, 1, 0};  // SW
      tbl[4] = '{32'h00208463, 1'b0, 0, 1, 0};  // BEQ not taken
      tbl[5] = '{32'h00208463, 1'b1, 0, 2, 0};  // BEQ taken
      tbl[6] = '{32'h008000EF, 1'b0, 1, 2, 2};  // JAL
      tbl[7] = '{32'h000010B7, 1'b0, 1, 1, 0};  // LUI
      opc_tbl = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                  7'b1100011, 7'b1101111, 7'b0110111};

      rst2 = 1'b0; rdy2 = 1'b0; instr2 = 32'h002081B3; br2 = 1'b0;

      // reset state
      rst_n = 1'b0; mem_ready = 1'b1; Instr = '0; br_taken = 1'b0;
      #3;
      chk("reset ctl", 32'(act), 32'h0);
      chk("reset cycle_cnt", cycle_cnt, 32'h0);
      chk("reset instret_cnt", instret_cnt, 32'h0);
      do_reset();

      // directed table, zero-wait memory
      foreach (tbl[i]) begin
         n_regwe = 0; n_pcwe = 0; last_wb = 0;
         run_instr(tbl[i].ins, tbl[i].br, 0, 0, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d reg_we pulses", i), 32'(n_regwe), 32'(tbl[i].regw));
         chk($sformatf("tbl%0d pc_we pulses", i), 32'(n_pcwe), 32'(tbl[i].pcw));
         chk($sformatf("tbl%0d wb_sel", i), 32'(last_wb), 32'(tbl[i].wb));
      end

      // LW with three wait cycles in MEM
      n_regwe = 0; last_wb = 0;
      run_instr(32'h0000A183, 1'b0, 0, 3, "lw_wait");
      chk("lw_wait wb_sel", 32'(last_wb), 32'd1);

      // random instruction stream with random memory waits
      for (int n = 0; n < 150; n++) begin
         r = $urandom;
         ins = {r[31:7], opc_tbl[$urandom_range(0, 6)]};
         run_instr(ins, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   $sformatf("rnd%0d", n));
      end

      // illegal opcode traps and stays trapped
      run_instr(32'h0000007F, 1'b0, 0, 0, "illegal");
      cyc_frozen = exp_cnt(m_cycles);
      for (int k = 0; k < 20; k++) step(P_T, C_BAD, $urandom, 1'($urandom), 1'($urandom), "trap");
      chk("trap cycle_cnt frozen", cycle_cnt, cyc_frozen);
      do_reset();

      // reset asserted during MEM of a store
      run_instr(32'h002081B3, 1'b0, 0, 0, "pre_sw");
      step(P_F, C_ST, $urandom, 1'b1, 1'b0, "sw_rst");
      step(P_D, C_ST, 32'h0020A023, 1'b0, 1'b0, "sw_rst");
      step(P_E, C_ST, 32'h0020A023, 1'b0, 1'b0, "sw_rst");
      step(P_M, C_ST, 32'h0020A023, 1'b0, 1'b0, "sw_rst");
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst mem_req", 32'(mem_req), 32'h0);
      chk("midrst mem_we", 32'(mem_we), 32'h0);
      chk("midrst ctl", 32'(act), 32'h0);
      chk("midrst cycle_cnt", cycle_cnt, 32'h0);
      chk("midrst instret_cnt", instret_cnt, 32'h0);
      do_reset();
      run_instr(32'h002081B3, 1'b0, 1, 0, "post_rst");

      // MEM_TIMEOUT=4: three waits are tolerated
      rst2 = 1'b0; rdy2 = 1'b0;
      @(posedge clk); #1;
      rst2 = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk($sformatf("t4 wait%0d trap", k), 32'(a_trap), 32'h0);
         @(posedge clk); #1;
      end
      rdy2 = 1'b1;
      @(negedge clk);
      chk("t4 late ready ir_we", 32'(a_irwe), 32'h1);
      @(posedge clk); #1;
      rdy2 = 1'b0;
      @(negedge clk);
      chk("t4 decode trap", 32'(a_trap), 32'h0);
      chk("t4 decode mem_req", 32'(a_req), 32'h0);
      @(posedge clk); #1;

      // MEM_TIMEOUT=4 traps on the 5th cycle; MEM_TIMEOUT=0 never traps
      rst2 = 1'b0;
      @(posedge clk); #1;
      rst2 = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk($sformatf("t4 cyc%0d trap", k), 32'(a_trap), (k == 5) ? 32'h1 : 32'h0);
         chk($sformatf("t4 cyc%0d mem_req", k), 32'(a_req), (k == 5) ? 32'h0 : 32'h1);
         @(posedge clk); #1;
      end
      for (int k = 6; k <= 1000; k++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("t4 cycle_cnt frozen", a_cyc, exp_cnt(4));
      chk("t0 trap", 32'(b_trap), 32'h0);
      chk("t0 mem_req", 32'(b_req), 32'h1);
      chk("t0 cycle_cnt", b_cyc, exp_cnt(1000));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
